// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 8x16 register file: pipeline, FPU and crypto writeback.
// Pipeline has priority, FPU/crypto alternate, starvation counters force F/C through.
module regfile_wb_arbiter #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p_valid,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_data,
   output logic              p_ready,
   output logic              p_stall,
   input  logic              f_valid,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic [DATA_W-1:0] f_data,
   output logic              f_ready,
   input  logic              c_valid,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_data,
   output logic              c_ready,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {RR_F = 1'b0, RR_C = 1'b1} rr_e;
   typedef enum logic [1:0] {SRC_NONE, SRC_P, SRC_F, SRC_C} src_e;

   rr_e               rr_q, rr_d;
   src_e              grant;
   logic [WAIT_W-1:0] f_wait_q, f_wait_d;
   logic [WAIT_W-1:0] c_wait_q, c_wait_d;
   logic              f_starved, c_starved;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [DATA_W-1:0] wr_data_d;

   assign f_starved = f_valid && (f_wait_q == WAIT_W'(MAX_WAIT));
   assign c_starved = c_valid && (c_wait_q == WAIT_W'(MAX_WAIT));
   assign p_stall   = p_valid && !p_ready;

   // Grant selection, round-robin pointer and wait-counter next state
   always_comb begin
      grant     = SRC_NONE;
      rr_d      = rr_q;
      f_wait_d  = '0;
      c_wait_d  = '0;
      p_ready   = 1'b0;
      f_ready   = 1'b0;
      c_ready   = 1'b0;
      wr_addr_d = rf_wr_addr;
      wr_data_d = rf_wr_data;

      if (f_starved && c_starved)
         grant = (rr_q == RR_C) ? SRC_C : SRC_F;
      else if (f_starved)
         grant = SRC_F;
      else if (c_starved)
         grant = SRC_C;
      else if (p_valid)
         grant = SRC_P;
      else if (f_valid && c_valid)
         grant = (rr_q == RR_C) ? SRC_C : SRC_F;
      else if (f_valid)
         grant = SRC_F;
      else if (c_valid)
         grant = SRC_C;

      case (grant)
         SRC_P: begin
            p_ready   = 1'b1;
            wr_addr_d = p_addr;
            wr_data_d = p_data;
         end
         SRC_F: begin
            f_ready   = 1'b1;
            rr_d      = RR_C;
            wr_addr_d = f_addr;
            wr_data_d = f_data;
         end
         SRC_C: begin
            c_ready   = 1'b1;
            rr_d      = RR_F;
            wr_addr_d = c_addr;
            wr_data_d = c_data;
         end
         default: ;
      endcase

      if (f_valid && !f_ready)
         f_wait_d = (f_wait_q == WAIT_W'(MAX_WAIT)) ? f_wait_q : f_wait_q + WAIT_W'(1);
      if (c_valid && !c_ready)
         c_wait_d = (c_wait_q == WAIT_W'(MAX_WAIT)) ? c_wait_q : c_wait_q + WAIT_W'(1);
   end

   // Arbitration state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q     <= RR_F;
         f_wait_q <= '0;
         c_wait_q <= '0;
      end else begin
         rr_q     <= rr_d;
         f_wait_q <= f_wait_d;
         c_wait_q <= c_wait_d;
      end
   end

   // Registered write port; address/data hold when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else begin
         rf_wr_en   <= (grant != SRC_NONE);
         rf_wr_addr <= wr_addr_d;
         rf_wr_data <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: priority, round-robin, starvation, withdrawal, reset.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p_valid, f_valid, c_valid;
   logic [2:0]  p_addr, f_addr, c_addr;
   logic [15:0] p_data, f_data, c_data;
   logic        p_ready, p_stall, f_ready, c_ready;
   logic        rf_wr_en;
   logic [2:0]  rf_wr_addr;
   logic [15:0] rf_wr_data;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_ready(p_ready), .p_stall(p_stall),
      .f_valid(f_valid), .f_addr(f_addr), .f_data(f_data), .f_ready(f_ready),
      .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
   );

   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p_valid = 0; f_valid = 0; c_valid = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; idle_inputs();
      p_addr = 0; p_data = 0; f_addr = 0; f_data = 0; c_addr = 0; c_data = 0;
      #1;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== 20'h0) begin
         errors++; $display("FAIL reset_outputs: got %b/%0d/%h want 0/0/0000", rf_wr_en, rf_wr_addr, rf_wr_data);
      end
      tick();
      rst_n = 1;
      tick();
      checks++;
      if (rf_wr_en !== 1'b0) begin
         errors++; $display("FAIL reset_no_write: rf_wr_en got %b want 0", rf_wr_en);
      end
   endtask

   task automatic test_p_alone();
      p_valid = 1; p_addr = 3; p_data = 16'h00A5;
      #1;
      checks++;
      if ({p_ready, p_stall, f_ready, c_ready} !== 4'b1000) begin
         errors++; $display("FAIL p_alone_ready: got %b want 1000", {p_ready, p_stall, f_ready, c_ready});
      end
      tick();
      p_valid = 0;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 3'd3, 16'h00A5}) begin
         errors++; $display("FAIL p_alone_write: got %b/%0d/%h want 1/3/00a5", rf_wr_en, rf_wr_addr, rf_wr_data);
      end
      tick();
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b0, 3'd3, 16'h00A5}) begin
         errors++; $display("FAIL p_alone_hold: got %b/%0d/%h want 0/3/00a5", rf_wr_en, rf_wr_addr, rf_wr_data);
      end
   endtask

   // rr_ptr is F out of reset and no F/C grant has happened yet
   task automatic test_fc_contention();
      logic exp_f [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      f_valid = 1; f_addr = 1; f_data = 16'h1111;
      c_valid = 1; c_addr = 2; c_data = 16'h2222;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({f_ready, c_ready, p_ready} !== {exp_f[i], !exp_f[i], 1'b0}) begin
            errors++; $display("FAIL fc_grant%0d: f/c/p got %b want %b", i, {f_ready, c_ready, p_ready}, {exp_f[i], !exp_f[i], 1'b0});
         end
         tick();
         checks++;
         if ({rf_wr_en, rf_wr_addr} !== {1'b1, exp_f[i] ? 3'd1 : 3'd2}) begin
            errors++; $display("FAIL fc_write%0d: got %b/%0d want 1/%0d", i, rf_wr_en, rf_wr_addr, exp_f[i] ? 1 : 2);
         end
      end
      idle_inputs();
      tick();
   endtask

   // Same address twice in a row: later write (F) lands last
   task automatic test_back_to_back();
      p_valid = 1; p_addr = 0; p_data = 16'h1234;
      f_valid = 1; f_addr = 0; f_data = 16'hABCD;
      #1;
      checks++;
      if ({p_ready, f_ready} !== 2'b10) begin
         errors++; $display("FAIL b2b_first: p/f got %b want 10", {p_ready, f_ready});
      end
      tick();
      p_valid = 0;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 3'd0, 16'h1234}) begin
         errors++; $display("FAIL b2b_write1: got %b/%0d/%h want 1/0/1234", rf_wr_en, rf_wr_addr, rf_wr_data);
      end
      tick();
      f_valid = 0;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 3'd0, 16'hABCD}) begin
         errors++; $display("FAIL b2b_write2: got %b/%0d/%h want 1/0/abcd", rf_wr_en, rf_wr_addr, rf_wr_data);
      end
      tick();
   endtask

   task automatic test_starvation();
      p_valid = 1; p_addr = 5; p_data = 16'h5555;
      f_valid = 1; f_addr = 6; f_data = 16'h6666;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (i == 4) begin
            if ({p_ready, p_stall, f_ready} !== 3'b011) begin
               errors++; $display("FAIL starve_cycle%0d: p_ready/p_stall/f_ready got %b want 011", i, {p_ready, p_stall, f_ready});
            end
         end else if ({p_ready, p_stall, f_ready} !== 3'b100) begin
            errors++; $display("FAIL starve_cycle%0d: p_ready/p_stall/f_ready got %b want 100", i, {p_ready, p_stall, f_ready});
         end
         tick();
         if (i == 4) begin
            checks++;
            if ({rf_wr_addr, rf_wr_data} !== {3'd6, 16'h6666}) begin
               errors++; $display("FAIL starve_write: got %0d/%h want 6/6666", rf_wr_addr, rf_wr_data);
            end
            f_valid = 0;
         end
      end
      idle_inputs();
      tick();
   endtask

   // rr_ptr is C after the forced F grant above
   task automatic test_both_starved();
      p_valid = 1; f_valid = 1; c_valid = 1;
      p_addr = 7; c_addr = 4; c_data = 16'hC0DE; f_addr = 6;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({p_ready, f_ready, c_ready} !== 3'b100) begin
            errors++; $display("FAIL both_pre%0d: p/f/c got %b want 100", i, {p_ready, f_ready, c_ready});
         end
         tick();
      end
      #1;
      checks++;
      if ({p_ready, f_ready, c_ready, p_stall} !== 4'b0011) begin
         errors++; $display("FAIL both_c_first: p/f/c/stall got %b want 0011", {p_ready, f_ready, c_ready, p_stall});
      end
      tick();
      c_valid = 0;
      checks++;
      if ({rf_wr_addr, rf_wr_data} !== {3'd4, 16'hC0DE}) begin
         errors++; $display("FAIL both_c_write: got %0d/%h want 4/c0de", rf_wr_addr, rf_wr_data);
      end
      checks++;
      if ({p_ready, f_ready, c_ready} !== 3'b010) begin
         errors++; $display("FAIL both_f_next: p/f/c got %b want 010", {p_ready, f_ready, c_ready});
      end
      tick();
      f_valid = 0;
      #1;
      checks++;
      if ({p_ready, p_stall} !== 2'b10) begin
         errors++; $display("FAIL both_p_after: p_ready/p_stall got %b want 10", {p_ready, p_stall});
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_withdrawal();
      p_valid = 1; f_valid = 1;
      tick();
      tick();
      f_valid = 0;
      tick();
      f_valid = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (f_ready !== (i == 4)) begin
            errors++; $display("FAIL withdraw_cycle%0d: f_ready got %b want %b", i, f_ready, i == 4);
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      p_valid = 1; p_addr = 2; p_data = 16'hBEEF;
      tick();
      checks++;
      if (rf_wr_en !== 1'b1) begin
         errors++; $display("FAIL rst_mid_pre: rf_wr_en got %b want 1", rf_wr_en);
      end
      rst_n = 0;
      #1;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== 20'h0) begin
         errors++; $display("FAIL rst_mid_async: got %b/%0d/%h want 0/0/0000", rf_wr_en, rf_wr_addr, rf_wr_data);
      end
      p_valid = 0;
      tick();
      rst_n = 1;
      tick();
      checks++;
      if (rf_wr_en !== 1'b0) begin
         errors++; $display("FAIL rst_mid_idle: rf_wr_en got %b want 0", rf_wr_en);
      end
      // rr_ptr back to F: contention must go to F first
      f_valid = 1; c_valid = 1;
      #1;
      checks++;
      if ({f_ready, c_ready} !== 2'b10) begin
         errors++; $display("FAIL rst_mid_rr: f/c got %b want 10", {f_ready, c_ready});
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_p_alone();
      test_fc_contention();
      test_back_to_back();
      test_starvation();
      test_both_starved();
      test_withdrawal();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
